// File: rtl/aes_pkg.sv
// Shared AES round-stage definitions: state byte type, stage FSM states and the
// forward/inverse S-box tables used by the encrypt and decrypt byte-substitution stages.
package aes_pkg;

    typedef logic [7:0] state_byte_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StDone    = 2'd2
    } stage_state_e;

    localparam int unsigned STATE_BYTES = 16;

    localparam state_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam state_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box: one byte in, its InvSubBytes substitute out.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  state_byte_t in_byte,
    output state_byte_t out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_subbytes.sv
// Byte-serial InvSubBytes stage: captures a 4x4 state, substitutes BYTES_PER_CYCLE bytes
// per cycle in column-major order, then holds the result until downstream accepts it.
module aes_inv_subbytes
    import aes_pkg::*;
#(
    parameter int unsigned STATE_ARRAY_DIMENSION = 4,
    parameter int unsigned BYTES_PER_CYCLE       = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic        next_is_ready,
    input  state_byte_t state_array     [STATE_ARRAY_DIMENSION][STATE_ARRAY_DIMENSION],
    output state_byte_t state_array_out [STATE_ARRAY_DIMENSION][STATE_ARRAY_DIMENSION],
    output logic        ready,
    output logic        valid_out
);

    if (STATE_ARRAY_DIMENSION != 4 ||
        (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
         BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16)) begin : gen_param_check
        $error("aes_inv_subbytes: illegal STATE_ARRAY_DIMENSION or BYTES_PER_CYCLE");
    end

    // BYTES_PER_CYCLE divides 16, so k steps land exactly on K_LAST and wrap cleanly.
    localparam logic [3:0] K_STEP = 4'(BYTES_PER_CYCLE % 16);
    localparam logic [3:0] K_LAST = 4'(16 - BYTES_PER_CYCLE);

    stage_state_e state_q, state_d;
    logic [3:0]   k_q, k_d;
    state_byte_t  in_q  [STATE_BYTES];
    state_byte_t  in_d  [STATE_BYTES];
    state_byte_t  out_q [STATE_BYTES];
    state_byte_t  out_d [STATE_BYTES];
    logic [BYTES_PER_CYCLE*8-1:0] sbox_out;

    for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : gen_sbox
        aes_inv_sbox u_inv_sbox (
            .in_byte  (in_q[k_q + 4'(i)]),
            .out_byte (sbox_out[8*i +: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        in_d    = in_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    for (int unsigned k = 0; k < STATE_BYTES; k++) begin
                        in_d[4'(k)] = state_array[2'(k % 4)][2'(k / 4)];
                    end
                    k_d     = '0;
                    state_d = StRunning;
                end
            end
            StRunning: begin
                for (int unsigned i = 0; i < BYTES_PER_CYCLE; i++) begin
                    out_d[k_q + 4'(i)] = sbox_out[8*i +: 8];
                end
                k_d = k_q + K_STEP;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (next_is_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                k_d     = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            in_q    <= '{default: '0};
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STATE_BYTES; k++) begin
            state_array_out[2'(k % 4)][2'(k / 4)] = out_q[4'(k)];
        end
    end

    assign ready     = (state_q == StIdle);
    assign valid_out = (state_q == StDone);

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// Self-checking bench for aes_inv_subbytes: one instance per legal BYTES_PER_CYCLE, checked
// against an S-box model derived from GF(2^8) inversion and the affine transform.
module tb_aes_inv_subbytes;

    localparam int NUM_DUT = 5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         valid_s [NUM_DUT];
    logic         nir_s   [NUM_DUT];
    logic         ready_s [NUM_DUT];
    logic         vout_s  [NUM_DUT];
    logic [127:0] sa_flat [NUM_DUT];
    logic [127:0] so_flat [NUM_DUT];

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Vectors are k-ordered: byte k (k = col*4 + row) sits at bits [127-8k -: 8].
    function automatic logic [127:0] pack_state(input logic [7:0] a [4][4]);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = a[k%4][k/4];
        return v;
    endfunction

    for (genvar g = 0; g < NUM_DUT; g++) begin : gen_dut
        logic [7:0] sa_l [4][4];
        logic [7:0] so_l [4][4];
        always_comb begin
            for (int k = 0; k < 16; k++) sa_l[k%4][k/4] = sa_flat[g][127-8*k -: 8];
        end
        assign so_flat[g] = pack_state(so_l);
        aes_inv_subbytes #(
            .STATE_ARRAY_DIMENSION (4),
            .BYTES_PER_CYCLE       (1 << g)
        ) u_dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .valid           (valid_s[g]),
            .next_is_ready   (nir_s[g]),
            .state_array     (sa_l),
            .state_array_out (so_l),
            .ready           (ready_s[g]),
            .valid_out       (vout_s[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ 8'h63;
            r = inv;
            for (int j = 0; j < 4; j++) begin
                r = rotl8(r);
                s = s ^ r;
            end
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] inv_ref(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[v[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fwd_ref(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = fwd_tab[v[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One job with latency and optional DONE-state backpressure; inputs are scrambled
    // right after acceptance and during backpressure to show they are ignored.
    task automatic run_job(input int g, input logic [127:0] din, input logic [127:0] dexp,
                           input int bp_cycles, input string tag);
        int lat;
        @(negedge clk);
        check_eq($sformatf("%s/g%0d/ready_idle", tag, g), ready_s[g], 1'b1);
        sa_flat[g] = din;
        valid_s[g] = 1'b1;
        nir_s[g]   = 1'b0;
        @(posedge clk);
        #1;
        valid_s[g] = 1'b0;
        sa_flat[g] = rand128();
        check_eq($sformatf("%s/g%0d/ready_busy", tag, g), ready_s[g], 1'b0);
        lat = 0;
        while (!vout_s[g] && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check_eq($sformatf("%s/g%0d/latency", tag, g), 128'(lat), 128'(16 >> g));
        check_eq($sformatf("%s/g%0d/data", tag, g), so_flat[g], dexp);
        for (int c = 0; c < bp_cycles; c++) begin
            @(negedge clk);
            valid_s[g] = 1'($urandom());
            sa_flat[g] = rand128();
            @(posedge clk);
            #1;
            check_eq($sformatf("%s/g%0d/bp_vout", tag, g), vout_s[g], 1'b1);
            check_eq($sformatf("%s/g%0d/bp_ready", tag, g), ready_s[g], 1'b0);
            check_eq($sformatf("%s/g%0d/bp_data", tag, g), so_flat[g], dexp);
        end
        @(negedge clk);
        valid_s[g] = 1'b0;
        nir_s[g]   = 1'b1;
        @(posedge clk);
        #1;
        check_eq($sformatf("%s/g%0d/release_vout", tag, g), vout_s[g], 1'b0);
        check_eq($sformatf("%s/g%0d/release_ready", tag, g), ready_s[g], 1'b1);
        nir_s[g] = 1'b0;
    endtask

    // valid and next_is_ready held high; jobs should start every lat+2 edges.
    task automatic run_b2b(input int g, input int njobs);
        int lat, per, r;
        logic [127:0] drv [$];
        lat = 16 >> g;
        per = lat + 2;
        for (int m = 0; m < njobs * per; m++) begin
            @(negedge clk);
            valid_s[g] = 1'b1;
            nir_s[g]   = 1'b1;
            sa_flat[g] = rand128();
            drv.push_back(sa_flat[g]);
            @(posedge clk);
            #1;
            r = m % per;
            check_eq($sformatf("b2b/g%0d/m%0d/ready", g, m), ready_s[g], r == per - 1);
            check_eq($sformatf("b2b/g%0d/m%0d/vout", g, m), vout_s[g], r == lat);
            if (r == lat) begin
                check_eq($sformatf("b2b/g%0d/m%0d/data", g, m), so_flat[g],
                         inv_ref(drv[m - lat]));
            end
        end
        @(negedge clk);
        valid_s[g] = 1'b0;
        nir_s[g]   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]   spot_in  [4];
        logic [7:0]   spot_out [4];
        logic [127:0] orig, din;

        spot_in  = '{8'h00, 8'h16, 8'h52, 8'h01};
        spot_out = '{8'h52, 8'hff, 8'h48, 8'h09};
        reset_n = 1'b0;
        for (int g = 0; g < NUM_DUT; g++) begin
            valid_s[g] = 1'b0;
            nir_s[g]   = 1'b0;
            sa_flat[g] = '0;
        end
        build_tables();
        #2;
        for (int g = 0; g < NUM_DUT; g++) begin
            check_eq($sformatf("reset/g%0d/ready", g), ready_s[g], 1'b1);
            check_eq($sformatf("reset/g%0d/vout", g), vout_s[g], 1'b0);
            check_eq($sformatf("reset/g%0d/data", g), so_flat[g], '0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        run_job(0, 128'h637c777bf26b6fc53001672bfed7ab76,
                128'h000102030405060708090a0b0c0d0e0f, 0, "basic");

        for (int g = 0; g < NUM_DUT; g++) begin
            for (int i = 0; i < 4; i++) begin
                run_job(g, {16{spot_in[i]}}, {16{spot_out[i]}}, 0,
                        $sformatf("spot%02h", spot_in[i]));
            end
        end

        din = rand128();
        run_job(0, din, inv_ref(din), 10, "bp");
        din = rand128();
        run_job(2, din, inv_ref(din), 10, "bp");

        // Asynchronous reset five edges into a BYTES_PER_CYCLE=1 job.
        @(negedge clk);
        sa_flat[0] = rand128();
        valid_s[0] = 1'b1;
        @(posedge clk);
        #1;
        valid_s[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst/ready", ready_s[0], 1'b1);
        check_eq("midrst/vout", vout_s[0], 1'b0);
        check_eq("midrst/data", so_flat[0], '0);
        @(negedge clk);
        reset_n = 1'b1;
        din = rand128();
        run_job(0, din, inv_ref(din), 0, "after_rst");

        for (int g = 0; g < NUM_DUT; g++) run_b2b(g, 3);

        for (int i = 0; i < 100; i++) begin
            orig = rand128();
            run_job(i % NUM_DUT, fwd_ref(orig), orig, 0, $sformatf("rt%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_inv_subbytes.md
# aes_inv_subbytes

Byte-serial AES InvSubBytes stage for the decryption datapath. It is the inverse counterpart of the encrypt-side SubBytes stage and uses the same valid/ready stage handshake. It captures a 4x4 state array and replaces every byte with its FIPS-197 inverse S-box value, BYTES_PER_CYCLE bytes per clock. It sits between InvShiftRows and AddRoundKey in the decrypt round pipeline.

## Interface
- STATE_ARRAY_DIMENSION, 4: rows/columns of the state array; only 4 is legal.
- BYTES_PER_CYCLE, 1: bytes substituted per RUNNING cycle.
  - Legal values: 1, 2, 4, 8, 16.
  - Any other value is an elaboration error.

- clk  in  1: rising-edge clock.
- reset_n  in  1: reset, asynchronous assert, active-low.
- valid  in  1: upstream holds a valid state_array.
- next_is_ready  in  1: downstream accepts the result.
- state_array  in  8 x [4][4]: input state, indexed [row][col].
- state_array_out  out  8 x [4][4]: substituted state, registered.
- ready  out  1: block is idle and can accept input.
- valid_out  out  1: state_array_out holds a complete result.

## Operation
- Byte order index k = col*4 + row, so row advances first: (0,0),(1,0),(2,0),(3,0),(0,1)…(3,3).
- FSM states are IDLE, RUNNING and DONE.
- IDLE
  - ready=1.
  - On valid=1: copy state_array into internal in_reg, set k=0, go to RUNNING.
  - Otherwise stay in IDLE.
- RUNNING
  - Each cycle, out_reg[k+i] <= inv_sbox(in_reg[k+i]) for i in 0..BYTES_PER_CYCLE-1.
  - Then k += BYTES_PER_CYCLE.
  - When k+BYTES_PER_CYCLE == 16: go to DONE and wrap k to 0.
  - valid and upstream state_array are ignored in this state. Only in_reg is read, so upstream may change its data freely after the handshake.
- DONE
  - valid_out=1; state_array_out is stable.
  - On next_is_ready=1: go to IDLE.
  - A new input is not accepted in the same cycle, so there is one bubble cycle between jobs.
- state_array_out = out_reg at all times.
  - Bytes update progressively during RUNNING.
  - Values are valid only while valid_out=1.
  - out_reg holds its value in IDLE until overwritten by the next job.
- Undefined FSM encoding returns to IDLE.
- The k counter is 4 bits wide. Overflow cannot occur because BYTES_PER_CYCLE divides 16.

## Timing
- Reset (reset_n=0, asynchronous) sets:
  - state=IDLE, k=0.
  - in_reg and out_reg all 0x00.
  - Outputs: ready=1, valid_out=0, state_array_out all 0x00.
- Reset mid-RUNNING or in DONE aborts the job immediately; the partial result is discarded (zeroed).
- Deassertion is synchronised externally; the block needs no ready cycle after release.
- Latency: acceptance edge E, then valid_out=1 after edge E+16/BYTES_PER_CYCLE.
  - BYTES_PER_CYCLE=1: 16 cycles.
  - BYTES_PER_CYCLE=16: 1 cycle.
- ready drops on the cycle after E.
- Minimum job period: 16/BYTES_PER_CYCLE + 2 cycles, with next_is_ready held high.
- valid_out stays high indefinitely while next_is_ready=0.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry INV_SBOX constant, alongside the forward SBOX;
  - the state-array byte typedef;
  - the IDLE/RUNNING/DONE stage-state enum shared with the other round stages.
- Sub-module aes_inv_sbox: purely combinational 8-bit lookup from INV_SBOX.
  - Instantiated BYTES_PER_CYCLE times.
  - Inputs/outputs are muxed by k.

## Test plan
- Reset mid-RUNNING:
  - Start with BYTES_PER_CYCLE=1, then assert reset_n=0 at cycle 5 after acceptance.
  - Required: ready=1, valid_out=0 and all outputs 0x00 with no clock edge needed.
  - A new job after release completes normally.
- Basic vector, BYTES_PER_CYCLE=1:
  - Input k-ordered bytes 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76 | ca 82 c9 7d (k=0..19 wraps at 16: use first 16).
  - Required: output bytes 00..0f in k order.
  - Required: valid_out rises exactly 16 edges after acceptance.
- Spot values (all 16 bytes equal):
  - 0x00 -> 0x52.
  - 0x16 -> 0xff.
  - 0x52 -> 0x48.
  - 0x01 -> 0x09.
  - Run for each legal BYTES_PER_CYCLE; latency must be 16, 8, 4, 2, 1.
- Backpressure:
  - Hold next_is_ready=0 for 10 cycles in DONE.
  - Required: valid_out and outputs stable, ready=0.
  - Change upstream state_array and valid meanwhile; the output must be unaffected.
- Back-to-back jobs:
  - Keep valid=1 and next_is_ready=1 continuously.
  - Required: jobs accepted every 16/BYTES_PER_CYCLE+2 cycles.
  - Required: each result matches the inverse S-box of its own captured input.
  - Required: input changes after acceptance are ignored.
- Round-trip:
  - Feed 100 random states through the encrypt SubBytes stage, then through this block.
  - Required: output equals the original state bit-exact.
